// File: rtl/ysyx_040750_clint.sv
// Core-local interruptor: msip, mtime and mtimecmp behind a
// single-outstanding MMIO slave, driving mtip/msip into the CSR file.
//
// Ports:
//   I_sys_clk, I_rst_n            clock, async active-low reset
//   I_req_valid/O_req_ready       request handshake
//   I_req_wen/addr/wdata/wmask    request payload (addr[2:0] ignored)
//   O_resp_valid/I_resp_ready     response handshake
//   O_resp_rdata, O_resp_err      response payload
//   O_mtip, O_msip                interrupt-pending levels
module ysyx_040750_clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        I_sys_clk,
  input  logic        I_rst_n,
  input  logic        I_req_valid,
  output logic        O_req_ready,
  input  logic        I_req_wen,
  input  logic [31:0] I_req_addr,
  input  logic [63:0] I_req_wdata,
  input  logic [7:0]  I_req_wmask,
  output logic        O_resp_valid,
  input  logic        I_resp_ready,
  output logic [63:0] O_resp_rdata,
  output logic        O_resp_err,
  output logic        O_mtip,
  output logic        O_msip
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] pre_q;
  logic [63:0]   mtime_q;
  logic [63:0]   mtimecmp_q;
  logic          msip_q;
  logic          mtip_q;
  logic [63:0]   rdata_q;
  logic          err_q;

  logic [31:0] off;
  logic        sel_msip;
  logic        sel_cmp;
  logic        sel_time;
  logic        mapped;
  logic        accept;
  logic        wr;
  logic        hshk;
  logic        tick;
  logic [63:0] rd_val;
  logic [63:0] mtime_inc;

  function automatic logic [63:0] wmerge(
    input logic [63:0] old,
    input logic [63:0] d,
    input logic [7:0]  m
  );
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
    end
    return r;
  endfunction

  // Doubleword offset into the window; anything
  // outside the window lands on a non-matching value.
  assign off      = (I_req_addr & ~32'h7) - BASE_ADDR;
  assign sel_msip = (off == 32'h0000_0000);
  assign sel_cmp  = (off == 32'h0000_4000);
  assign sel_time = (off == 32'h0000_BFF8);
  assign mapped   = sel_msip | sel_cmp | sel_time;

  assign accept = (state_q == S_IDLE) & I_req_valid;
  assign wr     = accept & I_req_wen & mapped;
  assign hshk   = (state_q == S_RESP) & I_resp_ready;

  assign tick      = (pre_q == PMAX);
  assign mtime_inc = mtime_q + (tick ? 64'd1 : 64'd0);

  always_comb begin
    rd_val = 64'd0;
    unique case (1'b1)
      sel_msip: rd_val = {63'd0, msip_q};
      sel_cmp:  rd_val = mtimecmp_q;
      sel_time: rd_val = mtime_q;
      default:  rd_val = 64'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    O_req_ready  = 1'b0;
    O_resp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        O_req_ready = 1'b1;
        if (I_req_valid) state_d = S_RESP;
      end
      S_RESP: begin
        O_resp_valid = 1'b1;
        if (I_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Written bytes override the tick; the rest
  // keep the incremented value.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mtime_q <= 64'd0;
    end else if (wr && sel_time) begin
      mtime_q <= wmerge(mtime_inc, I_req_wdata,
                        I_req_wmask);
    end else begin
      mtime_q <= mtime_inc;
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mtimecmp_q <= '1;
    end else if (wr && sel_cmp) begin
      mtimecmp_q <= wmerge(mtimecmp_q, I_req_wdata,
                           I_req_wmask);
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      msip_q <= 1'b0;
    end else if (wr && sel_msip && I_req_wmask[0]) begin
      msip_q <= I_req_wdata[0];
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mtip_q <= 1'b0;
    end else begin
      mtip_q <= (mtime_q >= mtimecmp_q);
    end
  end

  // Response payload is frozen at accept and
  // cleared once the consumer takes it.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= (I_req_wen || !mapped) ? 64'd0 : rd_val;
      err_q   <= ~mapped;
    end else if (hshk) begin
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end
  end

  assign O_resp_rdata = rdata_q;
  assign O_resp_err   = err_q;
  assign O_mtip       = mtip_q;
  assign O_msip       = msip_q;

endmodule

// File: tb/tb_ysyx_040750_clint.sv
// Randomized bench for ysyx_040750_clint: two instances (TICK_DIV 1
// and 4) checked every cycle against a behavioural register model.
module tb_ysyx_040750_clint;

  localparam logic [31:0] A_SIP  = 32'h0200_0000;
  localparam logic [31:0] A_CMP  = 32'h0200_4000;
  localparam logic [31:0] A_TIME = 32'h0200_BFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wen   [2];
  logic [31:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic [7:0]  req_wmask [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [63:0] resp_rdata[2];
  logic        resp_err  [2];
  logic        mtip      [2];
  logic        msip      [2];

  int n_cmp = 0;
  int n_bad = 0;

  int          td [2] = '{1, 4};
  logic [63:0] m_time[2];
  logic [63:0] m_cmp [2];
  logic        m_sip [2];
  logic        m_tip [2];
  int          m_pre [2];

  int          pw_k = -1;
  logic [31:0] pw_addr;
  logic [63:0] pw_data;
  logic [7:0]  pw_mask;

  always #5 clk = ~clk;

  ysyx_040750_clint #(
    .BASE_ADDR(32'h0200_0000),
    .TICK_DIV (1)
  ) u_d1 (
    .I_sys_clk   (clk),
    .I_rst_n     (rst_n),
    .I_req_valid (req_valid[0]),
    .O_req_ready (req_ready[0]),
    .I_req_wen   (req_wen[0]),
    .I_req_addr  (req_addr[0]),
    .I_req_wdata (req_wdata[0]),
    .I_req_wmask (req_wmask[0]),
    .O_resp_valid(resp_valid[0]),
    .I_resp_ready(resp_ready[0]),
    .O_resp_rdata(resp_rdata[0]),
    .O_resp_err  (resp_err[0]),
    .O_mtip      (mtip[0]),
    .O_msip      (msip[0])
  );

  ysyx_040750_clint #(
    .BASE_ADDR(32'h0200_0000),
    .TICK_DIV (4)
  ) u_d4 (
    .I_sys_clk   (clk),
    .I_rst_n     (rst_n),
    .I_req_valid (req_valid[1]),
    .O_req_ready (req_ready[1]),
    .I_req_wen   (req_wen[1]),
    .I_req_addr  (req_addr[1]),
    .I_req_wdata (req_wdata[1]),
    .I_req_wmask (req_wmask[1]),
    .O_resp_valid(resp_valid[1]),
    .I_resp_ready(resp_ready[1]),
    .O_resp_rdata(resp_rdata[1]),
    .O_resp_err  (resp_err[1]),
    .O_mtip      (mtip[1]),
    .O_msip      (msip[1])
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] bmerge(
    input logic [63:0] o,
    input logic [63:0] d,
    input logic [7:0]  m
  );
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++)
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit is_mapped(input logic [31:0] a);
    logic [31:0] d;
    d = a & ~32'h7;
    return (d == A_SIP) || (d == A_CMP) || (d == A_TIME);
  endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_time[k] = 64'd0;
      m_cmp[k]  = '1;
      m_sip[k]  = 1'b0;
      m_tip[k]  = 1'b0;
      m_pre[k]  = 0;
    end
  endtask

  // One clock of the reference: timer tick every td
  // cycles, then any write landing on this edge.
  task automatic mstep(input int k);
    logic [63:0] t;
    logic        tip_n;
    t     = m_time[k];
    tip_n = (t >= m_cmp[k]);
    if (m_pre[k] == td[k] - 1) begin
      m_pre[k] = 0;
      t = t + 64'd1;
    end else begin
      m_pre[k] = m_pre[k] + 1;
    end
    if (pw_k == k) begin
      case (pw_addr & ~32'h7)
        A_SIP:  if (pw_mask[0]) m_sip[k] = pw_data[0];
        A_CMP:  m_cmp[k] = bmerge(m_cmp[k], pw_data, pw_mask);
        A_TIME: t = bmerge(t, pw_data, pw_mask);
        default: ;
      endcase
    end
    m_time[k] = t;
    m_tip[k]  = tip_n;
  endtask

  task automatic edge_step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) mstep(k);
    pw_k = -1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("mtip%0d", k), mtip[k], m_tip[k]);
      chk($sformatf("msip%0d", k), msip[k], m_sip[k]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) edge_step();
  endtask

  task automatic xact(input int k, input bit wen,
                      input logic [31:0] addr,
                      input logic [63:0] wd,
                      input logic [7:0] wm,
                      input int hold);
    logic [63:0] exp_d;
    logic        exp_e;
    exp_e = !is_mapped(addr);
    exp_d = 64'd0;
    if (!wen && !exp_e) begin
      case (addr & ~32'h7)
        A_SIP:   exp_d = {63'd0, m_sip[k]};
        A_CMP:   exp_d = m_cmp[k];
        default: exp_d = m_time[k];
      endcase
    end
    req_valid[k] = 1'b1;
    req_wen[k]   = wen;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    req_wmask[k] = wm;
    chk("req_ready_idle", req_ready[k], 1'b1);
    if (wen && !exp_e) begin
      pw_k    = k;
      pw_addr = addr;
      pw_data = wd;
      pw_mask = wm;
    end
    edge_step();
    req_valid[k] = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", resp_valid[k], 1'b1);
      chk("req_ready_busy", req_ready[k], 1'b0);
      chk("resp_err", resp_err[k], exp_e);
      chk("resp_rdata", resp_rdata[k], exp_d);
      if (h < hold) edge_step();
    end
    resp_ready[k] = 1'b1;
    edge_step();
    resp_ready[k] = 1'b0;
    chk("resp_done", resp_valid[k], 1'b0);
    chk("req_ready_back", req_ready[k], 1'b1);
  endtask

  task automatic chk_reset_outs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_rdy"}, req_ready[k], 1'b1);
      chk({tag, "_rv"},  resp_valid[k], 1'b0);
      chk({tag, "_rd"},  resp_rdata[k], 64'd0);
      chk({tag, "_er"},  resp_err[k], 1'b0);
      chk({tag, "_tip"}, mtip[k], 1'b0);
      chk({tag, "_sip"}, msip[k], 1'b0);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  m;
    int          k;
    int          r;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      req_wen[i]    = 1'b0;
      req_addr[i]   = 32'd0;
      req_wdata[i]  = 64'd0;
      req_wmask[i]  = 8'd0;
      resp_ready[i] = 1'b0;
    end
    mreset();
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rst_n = 1'b1;

    // Timebase and reset values
    xact(0, 1'b0, A_CMP, 64'd0, 8'h00, 0);
    xact(1, 1'b0, A_CMP, 64'd0, 8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      xact(1, 1'b0, A_TIME, 64'd0, 8'h00, 0);
      idle(i % 3);
    end

    // Timer set / clear
    xact(0, 1'b1, A_CMP, 64'd20, 8'hFF, 0);
    for (int i = 0; i < 40 && m_time[0] < 64'd24; i++)
      idle(1);
    chk("tip_on", mtip[0], 1'b1);
    xact(0, 1'b1, A_CMP, '1, 8'hFF, 0);
    idle(2);

    // Masked write racing a tick
    xact(0, 1'b1, A_TIME, 64'h1122_3344_5566_7780,
         8'hFF, 0);
    xact(0, 1'b1, A_TIME, 64'h0000_0000_0000_00AA,
         8'h01, 0);
    xact(0, 1'b0, A_TIME, 64'd0, 8'h00, 0);

    // Wrap-around
    xact(0, 1'b1, A_CMP, 64'd5, 8'hFF, 0);
    xact(0, 1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE,
         8'hFF, 0);
    idle(4);
    chk("tip_wrap_off", mtip[0], 1'b0);

    // Unmapped read with backpressure, then msip
    xact(0, 1'b0, 32'h0200_0008, 64'd0, 8'h00, 3);
    xact(0, 1'b1, A_SIP, 64'd1, 8'h01, 0);
    chk("msip_set", msip[0], 1'b1);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 1);
      r = $urandom_range(0, 6);
      d = {$urandom, $urandom};
      m = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                      : 8'hFF;
      case (r)
        0: a = A_SIP;
        1: begin
          a = A_CMP;
          if ($urandom_range(0, 1) == 1)
            d = m_time[k] + 64'($urandom_range(0, 30));
        end
        2: begin
          a = A_TIME;
          if ($urandom_range(0, 1) == 1)
            d = m_cmp[k] - 64'($urandom_range(0, 10));
        end
        3: a = 32'h0200_0008;
        4: a = 32'h0200_0000 | ($urandom & 32'hFFFF);
        5: a = 32'h0300_0000 | ($urandom & 32'hFFFFFF);
        default: a = A_TIME | ($urandom & 32'h7);
      endcase
      xact(k, 1'($urandom_range(0, 1)), a, d, m,
           $urandom_range(0, 3));
      idle($urandom_range(0, 3));
    end

    // Async reset while a response is pending
    xact(0, 1'b1, A_SIP, 64'd1, 8'h01, 0);
    xact(1, 1'b1, A_SIP, 64'd1, 8'h01, 0);
    xact(0, 1'b1, A_CMP, 64'd0, 8'hFF, 0);
    xact(1, 1'b1, A_CMP, 64'd0, 8'hFF, 0);
    idle(2);
    chk("pre_rst_tip", mtip[0], 1'b1);
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b0;
    req_addr[0]  = A_TIME;
    edge_step();
    req_valid[0] = 1'b0;
    chk("pre_rst_rv", resp_valid[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("arst");
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, 1'b0, A_CMP, 64'd0, 8'h00, 0);
    xact(0, 1'b0, A_SIP, 64'd0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_040750_clint.md
# ysyx_040750_clint

Core-local interruptor for the single-hart pipeline: holds the memory-mapped `msip`, `mtime` and `mtimecmp` registers and drives the machine timer and software interrupt-pending lines into the CSR unit's `mip`. It sits on the LSU's MMIO path as a single-outstanding request/response slave. It is the producer of the `mtip` level that the CSR file samples every cycle.

## Interface
- `BASE_ADDR`, 32'h0200_0000: base of the CLINT window.
- `TICK_DIV`, 1: clock cycles per `mtime` increment; must be ≥1.
- `I_sys_clk`  in  1  clock; all state is updated on the rising edge.
- `I_rst_n`  in  1  asynchronous, active-low reset.
- `I_req_valid`  in  1  request present.
- `O_req_ready`  out  1  block can accept a request.
- `I_req_wen`  in  1  1 = write, 0 = read.
- `I_req_addr`  in  32  byte address; bits [2:0] are ignored.
- `I_req_wdata`  in  64  write data.
- `I_req_wmask`  in  8  byte enables for writes.
- `O_resp_valid`  out  1  response present.
- `I_resp_ready`  in  1  consumer takes the response.
- `O_resp_rdata`  out  64  read data; 0 for writes and for errors.
- `O_resp_err`  out  1  address not mapped.
- `O_mtip`  out  1  timer interrupt pending; goes to the CSR `I_mtip`.
- `O_msip`  out  1  software interrupt pending.

## Operation
- Register map, as offsets from `BASE_ADDR`:
  - 0x0000 `msip`: only bit 0 is implemented; the other bits read 0.
  - 0x4000 `mtimecmp`: 64 bits.
  - 0xBFF8 `mtime`: 64 bits.
- Any other doubleword in the window, or any address outside it, is unmapped.
  - Response has `O_resp_err`=1 and rdata 0.
  - No register changes.
- Reset values:
  - `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, prescaler=0.
  - FSM is in IDLE.
  - Outputs: `O_req_ready`=1, `O_resp_valid`=0, `O_resp_rdata`=0, `O_resp_err`=0, `O_mtip`=0, `O_msip`=0.
- FSM states: IDLE and RESP.
  - IDLE: `O_req_ready`=1. If `I_req_valid`=1 the request is accepted and the FSM moves to RESP.
  - RESP: `O_req_ready`=0 and `O_resp_valid`=1. When `I_resp_ready`=1 the FSM returns to IDLE. IDLE cannot accept in that same cycle, so at most one transaction completes every two cycles.
- On the accept edge:
  - Writes update only the bytes enabled by `I_req_wmask`.
  - Reads capture the register value held before that edge. The captured data is held stable through RESP.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - On the cycle it holds TICK_DIV-1 it wraps to 0 and `mtime` increments.
  - With TICK_DIV=1, `mtime` increments every cycle.
  - Writes to `mtime` do not affect the prescaler.
- `mtime` wraps from 2^64-1 to 0. The comparison is unsigned 64-bit.
- Write to `mtime` in a tick cycle: the written bytes win. Unmasked bytes take the incremented value.
- `O_mtip` is a register: it loads (`mtime` ≥ `mtimecmp`) evaluated on the current register values every cycle. It is level-sensitive and clears only when the comparison becomes false, i.e. by software rewriting `mtimecmp` or `mtime`.
- `O_msip` = `msip[0]`, driven straight from the register.
- Asynchronous reset mid-transaction drops any pending response immediately; no partial write is retained beyond what already landed on a prior edge.

## Timing
- Request accepted at edge E: the write lands at E, and the response is valid from E until the handshake edge (E+1 at earliest).
- `O_mtip` follows the comparison with one edge of latency.
  - After a register update at edge E, `O_mtip` reflects the new comparison after edge E+1.
  - Free-running case: `mtime` reaches `mtimecmp` at edge T, so `O_mtip` rises after edge T+1.
- `O_msip` changes at the write edge itself.
- `O_resp_rdata` and `O_resp_err` must hold stable while `O_resp_valid`=1 and `I_resp_ready`=0.

## Test plan
- Reset and timebase: release reset with TICK_DIV=4 and read `mtime` repeatedly. Required:
  - `mtime` increments by 1 every 4 cycles.
  - `mtimecmp` reads all-ones.
  - `O_mtip`=0.
- Timer interrupt set and clear:
  - Write `mtimecmp`=20 with TICK_DIV=1. `O_mtip` rises exactly 1 cycle after `mtime` reaches 20.
  - Then write `mtimecmp`=all-ones. `O_mtip` falls 1 cycle after the write edge.
- Masked write plus concurrent tick: with `mtime`=0x1122_3344_5566_7780 and TICK_DIV=1, write 0xAA with wmask=8'h01. Next `mtime` = 0x1122_3344_5566_77AA.
- Wrap-around: write `mtime`=2^64-2 and `mtimecmp`=5. Required:
  - `O_mtip` goes to 1.
  - Two ticks later `mtime`=0, and `O_mtip` returns to 0 one cycle after that.
- Unmapped access and backpressure: read 0x0200_0008 and hold `I_resp_ready`=0 for 3 cycles. Required:
  - `O_resp_valid`=1 and `O_resp_err`=1 with rdata 0, all held stable.
  - `O_req_ready`=0 throughout.
  - A write to 0x0200_0000 with wdata 1 afterwards makes `O_msip`=1.
- Async reset mid-response: assert `I_rst_n`=0 while `O_resp_valid`=1. All outputs return to their reset values without waiting for a clock edge.
